// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
//
// Measures a player's reaction time, in milliseconds, from "lights out" to the
// player's button press. The running count and all results are kept as four
// BCD digits so they can drive a 7-segment display without conversion.
//
// Attempt flow:
//   IDLE/DONE --arm--> ARMED --lights_out--> TIMING --press--> DONE
//   A press while ARMED is a jump start. If the count reaches MAX_COUNT and
//   another tick arrives, the attempt ends as a timeout.
//
// Parameters:
//   MAX_COUNT   : BCD saturation value of the reaction count (ms)
//   SYNC_STAGES : number of button synchronizer flops (2 or 3)
//
// Ports:
//   clk          in   system clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   tick         in   one-cycle 1 ms enable pulse
//   arm          in   one-cycle pulse, light sequence has started
//   lights_out   in   one-cycle pulse, all lights off, race start
//   button       in   raw asynchronous push-button, active-high
//   reaction     out  last result, 4 BCD digits (ms)
//   best         out  lowest valid result since reset, 4 BCD digits
//   result_valid out  one-cycle pulse when reaction is updated
//   jump_start   out  level, last attempt was a jump start
//   timed_out    out  level, last attempt saturated at MAX_COUNT
//   busy         out  high while ARMED or TIMING
// -----------------------------------------------------------------------------
module reaction_timer #(
  parameter logic [15:0] MAX_COUNT   = 16'h9999,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        arm,
  input  logic        lights_out,
  input  logic        button,
  output logic [15:0] reaction,
  output logic [15:0] best,
  output logic        result_valid,
  output logic        jump_start,
  output logic        timed_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TIMING = 2'd2,
    DONE   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchronizer and press edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_d_q;
  logic                   btn_s;
  logic                   press_evt;

  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // values from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      btn_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], button};
      btn_d_q <= btn_s;
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Edge-based press: a button held across arm never yields a new edge, and
  // a long hold produces exactly one event.
  assign press_evt = btn_s & ~btn_d_q;

  // ---------------------------------------------------------------------------
  // BCD increment of a 4-digit value (digit 9 wraps to 0 and carries on)
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [15:0] reaction_q, reaction_d;
  logic [15:0] best_q,     best_d;
  logic        valid_q,    valid_d;
  logic        jump_q,     jump_d;
  logic        tmo_q,      tmo_d;
  logic        good_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 16'h0000;
      reaction_q <= 16'h0000;
      best_q     <= MAX_COUNT;
      valid_q    <= 1'b0;
      jump_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reaction_q <= reaction_d;
      best_q     <= best_d;
      valid_q    <= valid_d;
      jump_q     <= jump_d;
      tmo_q      <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and result logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    reaction_d  = reaction_q;
    best_d      = best_q;
    valid_d     = 1'b0;
    jump_d      = jump_q;
    tmo_d       = tmo_q;
    good_result = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // Presses and lights_out are ignored here; only arm starts an attempt.
        if (arm) begin
          state_d = ARMED;
          cnt_d   = 16'h0000;
          jump_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end

      ARMED: begin
        if (press_evt && lights_out) begin
          // Press in the very cycle the lights go out counts as a legal
          // zero-millisecond reaction, not a jump start.
          state_d     = DONE;
          reaction_d  = 16'h0000;
          valid_d     = 1'b1;
          good_result = 1'b1;
        end else if (press_evt) begin
          state_d    = DONE;
          reaction_d = 16'h0000;
          valid_d    = 1'b1;
          jump_d     = 1'b1;
        end else if (lights_out) begin
          state_d = TIMING;
          cnt_d   = 16'h0000;
        end
      end

      TIMING: begin
        if (press_evt) begin
          // A tick in the same cycle as the press is not counted.
          state_d     = DONE;
          reaction_d  = cnt_q;
          valid_d     = 1'b1;
          good_result = 1'b1;
        end else if (tick) begin
          if (cnt_q >= MAX_COUNT) begin
            state_d    = DONE;
            reaction_d = MAX_COUNT;
            valid_d    = 1'b1;
            tmo_d      = 1'b1;
          end else begin
            cnt_d = bcd_inc(cnt_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Packed BCD orders the same as its decimal value, so a plain unsigned
    // compare selects the faster time. Equal results leave best untouched.
    if (good_result && (reaction_d < best_q)) begin
      best_d = reaction_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign reaction     = reaction_q;
  assign best         = best_q;
  assign result_valid = valid_q;
  assign jump_start   = jump_q;
  assign timed_out    = tmo_q;
  assign busy         = (state_q == ARMED) || (state_q == TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
//
// Directed bench for reaction_timer. Stimulus pushes the hand-computed result
// of each attempt into a scoreboard queue; an independent monitor pops and
// compares whenever the DUT pulses result_valid.
// -----------------------------------------------------------------------------
module tb_reaction_timer;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        arm;
  logic        lights_out;
  logic        button;
  logic [15:0] reaction;
  logic [15:0] best;
  logic        result_valid;
  logic        jump_start;
  logic        timed_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] reaction;
    logic [15:0] best;
    logic        jump;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  reaction_timer #(
    .MAX_COUNT  (16'h9999),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .arm         (arm),
    .lights_out  (lights_out),
    .button      (button),
    .reaction    (reaction),
    .best        (best),
    .result_valid(result_valid),
    .jump_start  (jump_start),
    .timed_out   (timed_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every result_valid pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result_valid", 16'd1, 16'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("reaction",   reaction,   mon_e.reaction);
        check("best",       best,       mon_e.best);
        check("jump_start", {15'd0, jump_start}, {15'd0, mon_e.jump});
        check("timed_out",  {15'd0, timed_out},  {15'd0, mon_e.tmo});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pulse_lo();
    lights_out = 1'b1;
    cyc();
    lights_out = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  // Press the button; with two sync stages press_evt is high in the third
  // cycle, where tick / lights_out can be made coincident with it.
  task automatic press_with(input logic t, input logic lo);
    button = 1'b1;
    cyc();
    cyc();
    tick       = t;
    lights_out = lo;
    cyc();
    tick       = 1'b0;
    lights_out = 1'b0;
    button     = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic expect_result(input logic [15:0] r, input logic [15:0] b,
                               input logic j, input logic t);
    exp_t e;
    e.reaction = r;
    e.best     = b;
    e.jump     = j;
    e.tmo      = t;
    sb_q.push_back(e);
  endtask

  // Bounded wait for the monitor to consume all expected results.
  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
    check(name, 16'(sb_q.size()), 16'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic attempt(input int n, input logic [15:0] r,
                         input logic [15:0] b, input string name);
    pulse_arm();
    pulse_lo();
    ticks(n);
    expect_result(r, b, 1'b0, 1'b0);
    press_with(1'b0, 1'b0);
    drain(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    tick       = 1'b0;
    arm        = 1'b0;
    lights_out = 1'b0;
    button     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_reaction", reaction, 16'h0000);
    check("rst_best",     best,     16'h9999);
    check("rst_valid",    {15'd0, result_valid}, 16'd0);
    check("rst_jump",     {15'd0, jump_start},   16'd0);
    check("rst_tmo",      {15'd0, timed_out},    16'd0);
    check("rst_busy",     {15'd0, busy},         16'd0);
    rst_n = 1'b1;
    cyc();

    // Basic 237 ms attempt
    pulse_arm();
    check("armed_busy", {15'd0, busy}, 16'd1);
    pulse_lo();
    ticks(237);
    expect_result(16'h0237, 16'h0237, 1'b0, 1'b0);
    press_with(1'b0, 1'b0);
    drain("drain_0237");
    check("done_busy", {15'd0, busy}, 16'd0);
    check("done_jump", {15'd0, jump_start}, 16'd0);

    // Best tracking and BCD carries
    do_reset();
    attempt(412, 16'h0412, 16'h0412, "drain_0412");
    attempt(388, 16'h0388, 16'h0388, "drain_0388");
    attempt(500, 16'h0500, 16'h0388, "drain_0500");
    attempt(109, 16'h0109, 16'h0109, "drain_0109");

    // Jump start, then a late lights_out must be ignored
    pulse_arm();
    expect_result(16'h0000, 16'h0109, 1'b1, 1'b0);
    press_with(1'b0, 1'b0);
    drain("drain_jump");
    check("jump_level", {15'd0, jump_start}, 16'd1);
    check("jump_busy",  {15'd0, busy},       16'd0);
    pulse_lo();
    repeat (3) cyc();
    check("late_lo_busy",     {15'd0, busy}, 16'd0);
    check("late_lo_reaction", reaction,      16'h0000);
    check("late_lo_best",     best,          16'h0109);

    // Press coincident with a tick at 0050: that tick is not counted
    pulse_arm();
    pulse_lo();
    ticks(50);
    expect_result(16'h0050, 16'h0050, 1'b0, 1'b0);
    press_with(1'b1, 1'b0);
    drain("drain_0050");

    // Press coincident with lights_out: valid zero result
    pulse_arm();
    expect_result(16'h0000, 16'h0000, 1'b0, 1'b0);
    press_with(1'b0, 1'b1);
    drain("drain_coincident_lo");
    check("coinc_jump", {15'd0, jump_start}, 16'd0);

    // Timeout after 10000 ticks
    pulse_arm();
    pulse_lo();
    expect_result(16'h9999, 16'h0000, 1'b0, 1'b1);
    ticks(10000);
    drain("drain_timeout");
    check("tmo_level", {15'd0, timed_out}, 16'd1);
    check("tmo_busy",  {15'd0, busy},      16'd0);

    // Arm clears the flags; a second arm while ARMED is ignored
    pulse_arm();
    check("rearm_tmo",  {15'd0, timed_out},  16'd0);
    check("rearm_jump", {15'd0, jump_start}, 16'd0);
    check("rearm_busy", {15'd0, busy},       16'd1);
    pulse_arm();
    check("arm_ignored_busy", {15'd0, busy}, 16'd1);

    // Reset in the middle of TIMING at count 0100: no result
    pulse_lo();
    ticks(100);
    rst_n = 1'b0;
    #2;
    check("midrst_reaction", reaction, 16'h0000);
    check("midrst_best",     best,     16'h9999);
    check("midrst_valid",    {15'd0, result_valid}, 16'd0);
    check("midrst_jump",     {15'd0, jump_start},   16'd0);
    check("midrst_tmo",      {15'd0, timed_out},    16'd0);
    check("midrst_busy",     {15'd0, busy},         16'd0);
    #3;
    rst_n = 1'b1;
    repeat (5) cyc();
    check("post_rst_busy", {15'd0, busy}, 16'd0);

    // Button held across arm: only a fresh press counts
    button = 1'b1;
    repeat (3) cyc();
    pulse_arm();
    pulse_lo();
    ticks(20);
    check("held_busy", {15'd0, busy}, 16'd1);
    button = 1'b0;
    repeat (3) cyc();
    expect_result(16'h0020, 16'h0020, 1'b0, 1'b0);
    press_with(1'b0, 1'b0);
    drain("drain_held");

    repeat (5) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter MAX_COUNT, default 16'h9999, BCD saturation value of the reaction count (ms).
REQ-002 Parameter SYNC_STAGES, default 2, number of button synchronizer flops (2 or 3).
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tick  input  1  one-cycle 1 ms enable pulse, synchronous to clk.
REQ-006 arm  input  1  one-cycle pulse: light sequence has started.
REQ-007 lights_out  input  1  one-cycle pulse: all lights extinguished, race start.
REQ-008 button  input  1  raw asynchronous player push-button, active-high.
REQ-009 reaction  output  16  last result, 4 BCD digits, ms.
REQ-010 best  output  16  lowest valid result since reset, 4 BCD digits.
REQ-011 result_valid  output  1  one-cycle pulse when reaction is updated.
REQ-012 jump_start  output  1  level: last attempt was a jump start.
REQ-013 timed_out  output  1  level: last attempt saturated at MAX_COUNT.
REQ-014 busy  output  1  high in ARMED or TIMING.

Function
REQ-015 button SHALL pass through SYNC_STAGES flops; a press SHALL be the rising edge of the synchronized signal (press_evt, one cycle).
REQ-016 FSM states SHALL be IDLE, ARMED, TIMING, DONE; busy = (ARMED or TIMING).
REQ-017 IDLE or DONE + arm -> ARMED; counter cleared to 0000, jump_start and timed_out cleared same edge.
REQ-018 arm in ARMED or TIMING SHALL be ignored.
REQ-019 ARMED + press_evt (no lights_out) -> DONE; jump_start set, reaction := 0000, result_valid pulses, best unchanged.
REQ-020 ARMED + lights_out (no press) -> TIMING, counter 0000.
REQ-021 ARMED + lights_out and press_evt same cycle -> DONE as valid result reaction := 0000, jump_start stays 0.
REQ-022 TIMING: each tick with no press_evt SHALL increment the counter in BCD (digit 9 wraps to 0 with carry into next digit).
REQ-023 TIMING + press_evt -> DONE; reaction := counter (tick that cycle not counted), result_valid pulses.
REQ-024 Counter SHALL saturate at MAX_COUNT; a tick at MAX_COUNT -> DONE with reaction := MAX_COUNT, timed_out set, result_valid pulses, best unchanged.
REQ-025 On valid result (not jump start, not timeout), best := reaction if reaction < best (unsigned compare of BCD value); equal leaves best unchanged.
REQ-026 reaction, jump_start, timed_out SHALL hold in DONE and IDLE until the next result or arm.
REQ-027 press_evt in IDLE or DONE SHALL be ignored; lights_out outside ARMED ignored.
REQ-028 result_valid SHALL be asserted exactly one cycle per attempt, registered, on the edge entering DONE.
REQ-029 Button held continuously SHALL produce only one press_evt; a press already held when entering ARMED SHALL not count.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0000, reaction 0000, best MAX_COUNT, result_valid 0, jump_start 0, timed_out 0, synchronizer flops 0.
REQ-031 Reset asserted mid-TIMING SHALL abort the attempt with no result_valid pulse; operation resumes on first posedge after rst_n rises.

Verification
REQ-032 arm, lights_out, 237 ticks, press -> result_valid once, reaction 16'h0237, best 16'h0237, jump_start 0.
REQ-033 arm, press before lights_out -> jump_start 1, reaction 16'h0000, best unchanged, state DONE, later lights_out ignored.
REQ-034 arm, lights_out, 10000 ticks no press -> reaction 16'h9999, timed_out 1, best unchanged.
REQ-035 Two attempts 0412 then 0388, then 0500 -> best 16'h0412, 16'h0388, 16'h0388; 0109 ticks checks BCD carry 0099->0100 after 0109 -> best 16'h0109.
REQ-036 Press coincident with tick at count 0050 -> reaction 16'h0050; press coincident with lights_out -> reaction 16'h0000, jump_start 0.
REQ-037 rst_n pulsed low at count 0100 -> no result_valid, all outputs per REQ-030, busy 0.
